uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NUM_REQ byte-stream requesters.
- Grants the transmitter a whole packet at a time, in round-robin order.
- Honours the transmitter's buffer-full backpressure.
- Sequences baud-rate changes so they only take effect after a drain window with no writes.
- Sits between the client blocks and the transmitter's data / data-write / baud-select inputs.

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// Module : uart_tx_arbiter
// Brief  : Packet-granular round-robin sharing of one UART transmitter, with
//          drain-sequenced baud-rate changes.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int BAUD_SEL_WIDTH = 2,
  parameter int BAUD_RESET     = 0,
  parameter int DRAIN_CYCLES   = 4096
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  input  logic                          baud_update_i,
  input  logic [BAUD_SEL_WIDTH-1:0]     baud_value_i,
  output logic                          baud_pending_o,
  input  logic                          data_buffer_full_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          data_write_o,
  output logic [BAUD_SEL_WIDTH-1:0]     baudrate_select_o
);

  localparam int c_PTR_W = $clog2(NUM_REQ);
  localparam int c_CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_PTR_W-1:0]        c_PTR_RESET  = c_PTR_W'(NUM_REQ - 1);
  localparam logic [c_CNT_W-1:0]        c_DRAIN_LOAD = c_CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [BAUD_SEL_WIDTH-1:0] c_BAUD_RESET = BAUD_SEL_WIDTH'(BAUD_RESET);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NUM_REQ-1:0]        r_grant;
  logic [NUM_REQ-1:0]        w_grant_nxt;
  logic [c_PTR_W-1:0]        r_ptr;
  logic [c_PTR_W-1:0]        w_ptr_nxt;
  logic [c_PTR_W-1:0]        w_cand;
  logic                      w_found;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_write;
  logic [BAUD_SEL_WIDTH-1:0] r_baud_sel;
  logic [BAUD_SEL_WIDTH-1:0] r_baud_value;
  logic                      r_baud_pending;
  logic [c_CNT_W-1:0]        r_drain_cnt;
  logic                      w_accept;
  logic                      w_last;
  logic [DATA_WIDTH-1:0]     w_byte;

  assign req_ready_o       = (r_state == S_GRANT && !data_buffer_full_i) ?
                             (r_grant & req_valid_i) : '0;
  assign w_accept          = |req_ready_o;
  assign w_last            = |(req_ready_o & req_last_i);
  assign grant_o           = r_grant;
  assign data_o            = r_data;
  assign data_write_o      = r_write;
  assign baudrate_select_o = r_baud_sel;
  assign baud_pending_o    = r_baud_pending;

  always_comb begin
    w_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) w_byte = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= c_PTR_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cand      = r_ptr;
    w_found     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A queued baud change takes priority over starting a new packet.
        if (r_baud_pending) begin
          w_state_nxt = S_DRAIN;
        end else if (|req_valid_i) begin
          for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = c_PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid_i[w_cand]) begin
              w_found             = 1'b1;
              w_ptr_nxt           = w_cand;
              w_grant_nxt         = '0;
              w_grant_nxt[w_cand] = 1'b1;
            end
          end
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_accept && w_last) begin
          w_grant_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!baud_update_i && r_drain_cnt == '0) w_state_nxt = S_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_data         <= '0;
      r_write        <= 1'b0;
      r_baud_sel     <= c_BAUD_RESET;
      r_baud_value   <= c_BAUD_RESET;
      r_baud_pending <= 1'b0;
      r_drain_cnt    <= '0;
    end else begin
      r_write <= w_accept;
      if (w_accept) r_data <= w_byte;

      // A fresh update always wins; inside DRAIN it restarts the idle window.
      if (baud_update_i) begin
        r_baud_value   <= baud_value_i;
        r_baud_pending <= 1'b1;
        if (r_state == S_DRAIN) r_drain_cnt <= c_DRAIN_LOAD;
      end else if (r_state == S_DRAIN) begin
        if (r_drain_cnt == '0) begin
          r_baud_sel     <= r_baud_value;
          r_baud_pending <= 1'b0;
        end else begin
          r_drain_cnt <= r_drain_cnt - 1'b1;
        end
      end

      if (r_state == S_IDLE && r_baud_pending) r_drain_cnt <= c_DRAIN_LOAD;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// Module : tb_uart_tx_arbiter
// Brief  : Scoreboard bench for uart_tx_arbiter with directed packet vectors.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BW = 2;
  localparam int DC = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     valid, last, ready, grant;
  logic [NR*DW-1:0]  data;
  logic              bupd, bpend, full, dwr;
  logic [BW-1:0]     bval, bsel;
  logic [DW-1:0]     dout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .BAUD_SEL_WIDTH(BW),
    .BAUD_RESET(0), .DRAIN_CYCLES(DC)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
    .req_ready_o(ready), .grant_o(grant),
    .baud_update_i(bupd), .baud_value_i(bval), .baud_pending_o(bpend),
    .data_buffer_full_i(full), .data_o(dout), .data_write_o(dwr),
    .baudrate_select_o(bsel)
  );

  typedef struct packed { logic [7:0] d; logic l; } ent_t;
  typedef struct packed { logic [7:0] d; logic [31:0] cyc; } exp_t;

  ent_t        txq [NR][$];
  exp_t        sb[$];
  int          grant_log[$];
  int          gap_log[$];
  int          acc_cnt[NR];
  int          gap_cnt;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cyc = 0;
  logic [NR-1:0] prev_grant, s_grant, s_ready;
  logic        s_dwr, s_bpend;
  logic [BW-1:0] s_bsel;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      if (txq[k].size() > 0) begin
        valid[k]          = 1'b1;
        data[k*DW +: DW]  = txq[k][0].d;
        last[k]           = txq[k][0].l;
      end else begin
        valid[k]          = 1'b0;
        data[k*DW +: DW]  = '0;
        last[k]           = 1'b0;
      end
    end
  endtask

  // Samples one cycle at the falling edge, records accepted bytes, then
  // refreshes the requester inputs just after the next rising edge.
  task automatic step();
    ent_t e;
    @(negedge clk);
    s_grant = grant; s_ready = ready; s_dwr = dwr; s_bpend = bpend; s_bsel = bsel;
    if (grant == '0) begin
      gap_cnt++;
    end else begin
      if (prev_grant == '0) begin
        for (int k = 0; k < NR; k++) if (grant[k]) grant_log.push_back(k);
        gap_log.push_back(gap_cnt);
      end
      gap_cnt = 0;
    end
    prev_grant = grant;
    for (int k = 0; k < NR; k++) begin
      if (ready[k]) begin
        e = txq[k].pop_front();
        sb.push_back('{d: e.d, cyc: cyc + 1});
        acc_cnt[k]++;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_acc(input int k, input int target, input string name);
    int n = 0;
    while (acc_cnt[k] < target && n < 100) begin
      step();
      n++;
    end
    check(name, 32'(acc_cnt[k]), 32'(target));
  endtask

  task automatic wait_grant(input logic [NR-1:0] g, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (s_grant != g && n < 100);
    check(name, 32'(s_grant), 32'(g));
  endtask

  task automatic check_log(input string name, input int exp_q[$]);
    check({name, "_len"}, 32'(grant_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
      check(name, 32'(grant_log[i]), 32'(exp_q[i]));
  endtask

  task automatic push_pkt(input int k, input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++)
      txq[k].push_back('{d: b[i], l: (i == b.size() - 1)});
  endtask

  // Monitor: every write strobe must match the oldest accepted byte, one cycle late.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dwr) begin
        if (sb.size() == 0) begin
          check("spurious_write", {31'b0, dwr}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("wr_data", 32'(dout), 32'(e.d));
          check("wr_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int b;
    rst_n = 1'b1; valid = '0; data = '0; last = '0;
    bupd = 1'b0; bval = '0; full = 1'b0;
    gap_cnt = 0; prev_grant = '0; s_grant = '0;
    foreach (acc_cnt[k]) acc_cnt[k] = 0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_dwr",   32'(dwr), 0);
    check("rst_dout",  32'(dout), 0);
    check("rst_bsel",  32'(bsel), 0);
    check("rst_bpend", 32'(bpend), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round robin with every requester continuously valid, 1-byte packets.
    grant_log.delete(); gap_log.delete();
    push_pkt(0, '{8'hA0}); push_pkt(1, '{8'hA1}); push_pkt(2, '{8'hA2});
    push_pkt(3, '{8'hA3}); push_pkt(0, '{8'hA4});
    drive();
    wait_acc(0, 2, "rr_done");
    check_log("rr_order", '{0, 1, 2, 3, 0});
    for (int i = 1; i < gap_log.size(); i++) check("rr_gap", 32'(gap_log[i]), 1);

    // Three-byte packet on requester 0.
    grant_log.delete();
    b = acc_cnt[0];
    push_pkt(0, '{8'h11, 8'h22, 8'h33});
    drive();
    wait_acc(0, b + 3, "pkt3_done");
    check("pkt3_grant_held", 32'(s_grant), 32'h1);
    step();
    check("pkt3_grant_release", 32'(s_grant), 0);
    check_log("pkt3_order", '{0});

    // Requester 1 and 0 arrive mid-packet of requester 2.
    grant_log.delete();
    push_pkt(2, '{8'hC0, 8'hC1, 8'hC2});
    drive();
    wait_grant(4'b0100, "pkt2_grant");
    push_pkt(1, '{8'hD1}); push_pkt(0, '{8'hD0});
    drive();
    wait_acc(1, 2, "nopreempt_done");
    check_log("nopreempt_order", '{2, 0, 1});

    // Buffer-full backpressure for 5 cycles mid-packet.
    b = acc_cnt[0];
    push_pkt(0, '{8'h41, 8'h42, 8'h43, 8'h44});
    drive();
    wait_acc(0, b + 2, "full_pre");
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("full_ready", 32'(s_ready), 0);
      if (i > 0) check("full_dwr", 32'(s_dwr), 0);
    end
    full = 1'b0;
    wait_acc(0, b + 4, "full_resume");

    // Baud change requested mid-packet, applied after the drain window.
    b = acc_cnt[0];
    push_pkt(0, '{8'h51, 8'h52, 8'h53, 8'h54});
    drive();
    wait_grant(4'b0001, "baud_pkt_grant");
    bupd = 1'b1; bval = 2'd2;
    step();
    bupd = 1'b0; bval = 2'd0;
    step();
    check("baud_pending_set", 32'(s_bpend), 1);
    check("baud_sel_unchanged", 32'(s_bsel), 0);
    wait_acc(0, b + 4, "baud_pkt_done");
    push_pkt(1, '{8'h61});
    drive();
    for (int i = 1; i <= DC + 1; i++) begin
      step();
      check("drain_no_grant", 32'(s_grant), 0);
      check("drain_pending", 32'(s_bpend), 1);
    end
    step();
    check("baud_applied", 32'(s_bsel), 2);
    check("baud_pending_clr", 32'(s_bpend), 0);
    check("baud_idle_grant", 32'(s_grant), 0);
    step();
    check("post_drain_grant", 32'(s_grant), 32'h2);
    wait_acc(1, 3, "post_drain_done");

    // Reset in the middle of a packet.
    b = acc_cnt[2];
    push_pkt(2, '{8'h71, 8'h72, 8'h73, 8'h74});
    drive();
    wait_acc(2, b + 2, "rst_pkt_pre");
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_ready", 32'(ready), 0);
    check("mid_rst_dwr",   32'(dwr), 0);
    check("mid_rst_dout",  32'(dout), 0);
    check("mid_rst_bsel",  32'(bsel), 0);
    check("mid_rst_bpend", 32'(bpend), 0);
    sb.delete();
    txq[2].delete();
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    grant_log.delete(); prev_grant = '0;
    push_pkt(2, '{8'h82}); push_pkt(0, '{8'h80});
    drive();
    wait_acc(2, b + 3, "after_rst_done");
    check_log("after_rst_order", '{0, 2});

    repeat (3) step();
    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
